// File: rtl/sec_counter_display.sv
// Multi-digit BCD seconds/minutes counter with prescaled ticks, load/clear,
// and a time-multiplexed 7-segment driver with leading-zero blanking.
module sec_counter_display #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned PRESCALE       = 50000000,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned TIME_MODE      = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned BLANK_LZ       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  wrap,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned CW     = 4 * DIGITS;
  localparam int unsigned PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = (SEG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Largest legal value of digit i: 5 for odd digits in clock mode, else 9.
  function automatic logic [3:0] digit_max(input int i);
    return ((TIME_MODE != 0) && (i % 2 == 1)) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              wrap_q, wrap_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic              tick_c;
  logic              carry;
  logic [3:0]        dig;
  logic              higher_zero;
  logic              sel_blank;
  logic [3:0]        sel_digit;
  logic [6:0]        seg_raw;
  logic [DIGITS-1:0] an_raw;

  // Prescaler, ripple counter and load clamp; clear beats load beats tick.
  always_comb begin
    cnt_d  = cnt_q;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    dig    = 4'd0;
    tick_c = run && (pre_q == PRE_W'(PRESCALE - 1));
    carry  = tick_c;
    if (run) begin
      pre_d = tick_c ? '0 : pre_q + 1'b1;
    end
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig = cnt_q[4*i +: 4];
      if (carry) begin
        if (dig == digit_max(i)) begin
          cnt_d[4*i +: 4] = 4'd0;
        end else begin
          cnt_d[4*i +: 4] = dig + 4'd1;
          carry           = 1'b0;
        end
      end
    end
    wrap_d = carry;
    if (clear) begin
      cnt_d  = '0;
      pre_d  = '0;
      wrap_d = 1'b0;
    end else if (load) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        dig             = load_value[4*i +: 4];
        cnt_d[4*i +: 4] = (dig > digit_max(i)) ? digit_max(i) : dig;
      end
      pre_d  = '0;
      wrap_d = 1'b0;
    end
  end

  // Free-running scan; the displayed digit is blanked if it and all above are zero.
  always_comb begin
    scan_cnt_d  = scan_cnt_q + 1'b1;
    scan_idx_d  = scan_idx_q;
    higher_zero = 1'b1;
    sel_blank   = 1'b0;
    sel_digit   = 4'd0;
    an_raw      = '0;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
    end
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      higher_zero = higher_zero && (cnt_q[4*i +: 4] == 4'd0);
      if (IDX_W'(i) == scan_idx_q) begin
        sel_digit = cnt_q[4*i +: 4];
        sel_blank = higher_zero && (i != 0) && (BLANK_LZ != 0);
        an_raw[i] = 1'b1;
      end
    end
    seg_raw = sel_blank ? 7'h00 : decode(sel_digit);
    seg_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    an_d    = (SEG_ACTIVE_LOW != 0) ? ~an_raw : an_raw;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      pre_q      <= '0;
      wrap_q     <= 1'b0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      seg_q      <= SEG_OFF;
      an_q       <= AN_OFF;
    end else begin
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      wrap_q     <= wrap_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign bcd_out = cnt_q;
  assign wrap    = wrap_q;
  assign seg     = seg_q;
  assign an      = an_q;

endmodule

// File: tb/tb_sec_counter_display.sv
// Bench for sec_counter_display (4-digit mm:ss, prescale 2, scan 3): directed
// scenarios plus random traffic against an elapsed-seconds reference model.
module tb_sec_counter_display;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 2;
  localparam int SCAN_DIV = 3;
  localparam int TOTAL    = 3600;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;
  logic [15:0] bcd_out;
  logic        wrap;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks = 0;
  int failures = 0;

  // Reference state: count as whole seconds, scan as cycles since reset.
  int         m_secs = 0;
  int         m_pre = 0;
  int         m_elapsed = 0;
  logic       m_wrap = 1'b0;
  logic [6:0] m_seg = 7'h7F;
  logic [3:0] m_an = 4'hF;

  int         mods[4]    = '{10, 6, 10, 6};
  int         place[4]   = '{1, 10, 60, 600};
  logic [6:0] seg_tab[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  sec_counter_display #(
    .DIGITS(4), .PRESCALE(2), .SCAN_DIV(3),
    .TIME_MODE(1), .SEG_ACTIVE_LOW(1), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clear(clear), .load(load),
    .load_value(load_value), .bcd_out(bcd_out), .wrap(wrap), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s / 10) % 6), 4'(s % 10)};
  endfunction

  function automatic int from_bcd_clamped(input logic [15:0] v);
    int total = 0;
    for (int i = 0; i < 4; i++) begin
      int d = int'(v[4*i +: 4]);
      if (d > mods[i] - 1) d = mods[i] - 1;
      total += d * place[i];
    end
    return total;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Predicts registered outputs after the coming edge from current inputs.
  task automatic model_update();
    int idx;
    logic [15:0] cur;
    logic tick;
    if (!rst_n) begin
      m_secs = 0; m_pre = 0; m_elapsed = 0; m_wrap = 1'b0;
      m_seg = 7'h7F; m_an = 4'hF;
      return;
    end
    idx  = (m_elapsed / SCAN_DIV) % DIGITS;
    cur  = to_bcd(m_secs);
    m_an = ~(4'b0001 << idx);
    if (idx != 0 && m_secs < place[idx]) m_seg = 7'h7F;
    else m_seg = ~seg_tab[cur[4*idx +: 4]];
    m_elapsed++;
    tick   = run && (m_pre == PRESCALE - 1);
    m_wrap = 1'b0;
    if (clear) begin
      m_secs = 0; m_pre = 0;
    end else if (load) begin
      m_secs = from_bcd_clamped(load_value); m_pre = 0;
    end else begin
      if (run) m_pre = (m_pre + 1) % PRESCALE;
      if (tick) begin
        m_wrap = (m_secs == TOTAL - 1);
        m_secs = (m_secs + 1) % TOTAL;
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check("bcd", 32'(bcd_out), 32'(to_bcd(m_secs)));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("seg", 32'(seg), 32'(m_seg));
    check("an", 32'(an), 32'(m_an));
  endtask

  initial begin
    bit found;

    // Reset
    rst_n = 1'b0;
    step(); step();
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    rst_n = 1'b1;

    // 1: 20 running cycles give 10 ticks
    run = 1'b1;
    repeat (20) step();
    check("t1_bcd", 32'(bcd_out), 32'h0010);

    // 2: roll over from 59:59
    run = 1'b0; load = 1'b1; load_value = 16'h5959;
    step();
    load = 1'b0; run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      step();
      if (wrap) found = 1'b1;
    end
    check("t2_wrap_seen", 32'(found), 32'h1);
    check("t2_bcd_zero", 32'(bcd_out), 32'h0);
    step();
    check("t2_wrap_drop", 32'(wrap), 32'h0);

    // 3: clamped load, held while stopped
    run = 1'b0; load = 1'b1; load_value = 16'h0A7F;
    step();
    load = 1'b0;
    check("t3_clamp", 32'(bcd_out), 32'h0959);
    repeat (10) step();
    check("t3_hold", 32'(bcd_out), 32'h0959);

    // 4: scan 0x0042 with blanking
    load = 1'b1; load_value = 16'h0042;
    step();
    load = 1'b0;
    repeat (14) begin
      step();
      if (an == 4'hE) check("t4_seg_d0", 32'(seg), 32'h24);
      if (an == 4'hD) check("t4_seg_d1", 32'(seg), 32'h19);
      if (an == 4'hB || an == 4'h7) check("t4_seg_blank", 32'(seg), 32'h7F);
    end

    // 5: clear coincident with a tick at 0x0009
    load = 1'b1; load_value = 16'h0009;
    step();
    load = 1'b0; run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (m_pre == PRESCALE - 1) begin
        clear = 1'b1;
        step();
        clear = 1'b0;
        found = 1'b1;
      end else begin
        step();
      end
    end
    check("t5_tick_found", 32'(found), 32'h1);
    check("t5_clr_bcd", 32'(bcd_out), 32'h0);
    check("t5_clr_wrap", 32'(wrap), 32'h0);
    step();
    check("t5_no_early", 32'(bcd_out), 32'h0);
    step();
    check("t5_first", 32'(bcd_out), 32'h0001);
    clear = 1'b1; load = 1'b1; load_value = 16'h0555;
    step();
    clear = 1'b0; load = 1'b0;
    check("t5_clr_load", 32'(bcd_out), 32'h0);

    // 6: reset mid-count and mid-scan
    load = 1'b1; load_value = 16'h0123;
    step();
    load = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6_bcd", 32'(bcd_out), 32'h0);
    check("t6_seg", 32'(seg), 32'h7F);
    check("t6_an", 32'(an), 32'hF);
    step();
    check("t6_scan0", 32'(an), 32'hE);
    repeat (6) step();

    // Random traffic
    repeat (1500) begin
      run        = ($urandom_range(0, 9) < 7);
      clear      = ($urandom_range(0, 99) < 3);
      load       = ($urandom_range(0, 99) < 5);
      load_value = 16'($urandom);
      rst_n      = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
